// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared type definitions for the core execution units.
//
// mul_op_e selects which 32 bits of the 64-bit product the multiplier returns
// and how each operand's sign is interpreted:
//   MUL_MUL    : low word, signedness irrelevant
//   MUL_MULH   : high word, signed x signed
//   MUL_MULHSU : high word, signed rs1 x unsigned rs2
//   MUL_MULHU  : high word, unsigned x unsigned
// -----------------------------------------------------------------------------
package core_pkg;

  typedef enum logic [1:0] {
    MUL_MUL    = 2'd0,
    MUL_MULH   = 2'd1,
    MUL_MULHSU = 2'd2,
    MUL_MULHU  = 2'd3
  } mul_op_e;

endpackage : core_pkg

// File: rtl/core_mul_seq_if.sv
// -----------------------------------------------------------------------------
// core_mul_seq_if
// Request/response bundle for the sequential multiplier.
//
// Signals:
//   flush      master->slave  abort the current operation
//   mul_op     master->slave  operation select (core_pkg::mul_op_e)
//   src_a      master->slave  multiplicand (rs1)
//   src_b      master->slave  multiplier (rs2)
//   in_valid   master->slave  request presents mul_op/src_a/src_b
//   in_ready   slave->master  multiplier can accept a request
//   out_valid  slave->master  mul_result is valid
//   out_ready  master->slave  consumer accepts mul_result
//   mul_result slave->master  selected 32 bits of the product
//
// Modports: master = requester/consumer side, slave = multiplier side.
// -----------------------------------------------------------------------------
interface core_mul_seq_if;
  import core_pkg::*;

  logic        flush;
  mul_op_e     mul_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] mul_result;

  modport master (
    output flush, mul_op, src_a, src_b, in_valid, out_ready,
    input  in_ready, out_valid, mul_result
  );

  modport slave (
    input  flush, mul_op, src_a, src_b, in_valid, out_ready,
    output in_ready, out_valid, mul_result
  );

endinterface : core_mul_seq_if

// File: rtl/core_mul_seq.sv
// -----------------------------------------------------------------------------
// core_mul_seq
// Iterative 32x32 multiplier supporting MUL / MULH / MULHSU / MULHU.
//
// Operands are converted to sign + magnitude on acceptance, multiplied
// unsigned by shift-and-add over a fixed number of iterations, and the
// 64-bit product is negated at the output when exactly one operand was
// negative. Latency is fixed (no early-out): out_valid rises exactly ITER
// clock edges after the accepting edge.
//
// Ports:
//   clk    core clock, all state changes on the rising edge
//   rst_n  synchronous active-low reset
//   bus    core_mul_seq_if.slave (request, response, flush)
//
// Configuration macro:
//   CORE_MUL_RADIX4_EN  defined   -> radix-4 datapath, ITER = 16
//                       undefined -> radix-2 datapath, ITER = 32
//   Results are bit-identical in both builds.
// -----------------------------------------------------------------------------
module core_mul_seq
  import core_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  core_mul_seq_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

`ifdef CORE_MUL_RADIX4_EN
  localparam int unsigned ITER = 16;
`else
  localparam int unsigned ITER = 32;
`endif

  localparam logic [4:0] CNT_INIT = 5'(ITER - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]  state_q,  state_d;
  logic [4:0]  cnt_q,    cnt_d;
  logic [63:0] acc_q,    acc_d;     // {upper partial sum, retired product bits}
  logic [31:0] mplr_q,   mplr_d;    // remaining multiplier bits, LSB first
  logic [31:0] mag_a_q,  mag_a_d;   // multiplicand magnitude
  mul_op_e     op_q,     op_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;

  // ---------------------------------------------------------------------------
  // Request decode: sign flags and operand magnitudes
  // ---------------------------------------------------------------------------
  logic        req_sign_a;
  logic        req_sign_b;
  logic [31:0] req_mag_a;
  logic [31:0] req_mag_b;
  logic        accept;

  assign req_sign_a = ((bus.mul_op == MUL_MULH) || (bus.mul_op == MUL_MULHSU))
                      & bus.src_a[31];
  assign req_sign_b = (bus.mul_op == MUL_MULH) & bus.src_b[31];
  assign req_mag_a  = req_sign_a ? (~bus.src_a + 32'd1) : bus.src_a;
  assign req_mag_b  = req_sign_b ? (~bus.src_b + 32'd1) : bus.src_b;

  // flush in IDLE blocks acceptance even when in_valid is high.
  assign accept = bus.in_valid & (state_q == ST_IDLE) & ~bus.flush;

  // ---------------------------------------------------------------------------
  // One iteration of the shift-and-add datapath
  // ---------------------------------------------------------------------------
  logic [63:0] step_acc;
  logic [31:0] step_mplr;

`ifdef CORE_MUL_RADIX4_EN
  // Two multiplier bits per edge. The partial product is at most 3a, so the
  // upper half plus partial product fits in 34 bits; those 34 bits become the
  // new upper 34 accumulator bits as the whole accumulator shifts right by 2.
  logic [33:0] pp_r4;
  logic [33:0] sum_r4;

  always_comb begin
    // NOTE: every signal assigned in an always_comb gets a value on every
    // path (defaults first or a full case), otherwise a latch is inferred.
    pp_r4 = 34'd0;
    unique case (mplr_q[1:0])
      2'b00: pp_r4 = 34'd0;
      2'b01: pp_r4 = {2'b00, mag_a_q};
      2'b10: pp_r4 = {1'b0, mag_a_q, 1'b0};
      2'b11: pp_r4 = {2'b00, mag_a_q} + {1'b0, mag_a_q, 1'b0};
      default: pp_r4 = 34'd0;
    endcase
    sum_r4    = {2'b00, acc_q[63:32]} + pp_r4;
    step_acc  = {sum_r4, acc_q[31:2]};
    step_mplr = {2'b00, mplr_q[31:2]};
  end
`else
  // One multiplier bit per edge: the 33-bit sum (carry included) becomes the
  // upper 33 accumulator bits as the whole accumulator shifts right by 1.
  logic [32:0] sum_r2;

  always_comb begin
    sum_r2    = {1'b0, acc_q[63:32]} + (mplr_q[0] ? {1'b0, mag_a_q} : 33'd0);
    step_acc  = {sum_r2, acc_q[31:1]};
    step_mplr = {1'b0, mplr_q[31:1]};
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mplr_d   = mplr_q;
    mag_a_d  = mag_a_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_BUSY;
          cnt_d    = CNT_INIT;
          acc_d    = 64'd0;
          mplr_d   = req_mag_b;
          mag_a_d  = req_mag_a;
          op_d     = bus.mul_op;
          sign_a_d = req_sign_a;
          sign_b_d = req_sign_b;
        end
      end

      ST_BUSY: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d  = step_acc;
          mplr_d = step_mplr;
          if (cnt_q == 5'd0) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end

      ST_DONE: begin
        // Accumulator is frozen here, which keeps mul_result stable.
        if (bus.flush || bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      // NOTE: the datapath registers are reset as well as the control state,
      // because mul_result must read zero straight after reset.
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      mplr_q   <= 32'd0;
      mag_a_q  <= 32'd0;
      op_q     <= MUL_MUL;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mplr_q   <= mplr_d;
      mag_a_q  <= mag_a_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [63:0] product;

  // The accumulator holds |a| * |b|; restore the sign when exactly one
  // operand was negative.
  assign product = (sign_a_q ^ sign_b_q) ? (~acc_q + 64'd1) : acc_q;

  assign bus.mul_result = (op_q == MUL_MUL) ? product[31:0] : product[63:32];
  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = (state_q == ST_DONE);

endmodule : core_mul_seq

// File: tb/tb_core_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_core_mul_seq
// Self-checking bench for core_mul_seq: a table of directed vectors with
// hand-computed results, plus sequences for reset, backpressure and flush.
// Build with +define+CORE_MUL_RADIX4_EN to exercise the radix-4 datapath.
// -----------------------------------------------------------------------------
module tb_core_mul_seq;
  import core_pkg::*;

`ifdef CORE_MUL_RADIX4_EN
  localparam int ITER = 16;
`else
  localparam int ITER = 32;
`endif

  localparam int WAIT_LIMIT = ITER + 20;

  logic clk;
  logic rst_n;

  core_mul_seq_if bus ();

  core_mul_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    mul_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a request for one edge; called at posedge+1.
  task automatic accept_req(input mul_op_e op, input logic [31:0] a,
                            input logic [31:0] b);
    bus.mul_op   = op;
    bus.src_a    = a;
    bus.src_b    = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges until out_valid, bounded; returns at posedge+1.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < WAIT_LIMIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input mul_op_e op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res,
                        output int lat);
    accept_req(op, a, b);
    wait_valid(lat);
    res = bus.mul_result;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] held;
    int          lat;
    int          seen;

    vecs[0]  = '{MUL_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{MUL_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{MUL_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{MUL_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[4]  = '{MUL_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[5]  = '{MUL_MULHSU, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001};
    vecs[6]  = '{MUL_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
    vecs[7]  = '{MUL_MUL,    32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
    vecs[8]  = '{MUL_MULH,   32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[9]  = '{MUL_MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};
    vecs[10] = '{MUL_MUL,    32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001};
    vecs[11] = '{MUL_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[12] = '{MUL_MUL,    32'h0000_0003, 32'h0000_0007, 32'h0000_0015};
    vecs[13] = '{MUL_MUL,    32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFC};

    // ---- Reset with a request already pending --------------------------------
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    bus.mul_op    = MUL_MULHU;
    bus.src_a     = 32'h0001_0000;
    bus.src_b     = 32'h0001_0000;
    bus.in_valid  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready",   64'(bus.in_ready),   64'd1);
    check("reset_out_valid",  64'(bus.out_valid),  64'd0);
    check("reset_mul_result", 64'(bus.mul_result), 64'h0);

    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("accept_first_edge_in_ready", 64'(bus.in_ready), 64'd0);
    wait_valid(lat);
    check("post_reset_latency", 64'(lat), 64'(ITER));
    check("post_reset_result",  64'(bus.mul_result), 64'h1);
    release_result();
    check("post_reset_idle", 64'(bus.in_ready), 64'd1);

    // ---- Directed vector table --------------------------------------------
    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_result", i),  64'(res), 64'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(ITER));
      release_result();
      check($sformatf("vec%0d_idle", i), 64'(bus.in_ready), 64'd1);
    end

    // ---- Backpressure: result held while out_ready stays low -------------------
    run_op(MUL_MUL, 32'h0000_0007, 32'hFFFF_FFFD, held, lat);
    check("bp_result", 64'(held), 64'hFFFF_FFEB);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_valid_c%0d", c),  64'(bus.out_valid),  64'd1);
      check($sformatf("bp_stable_c%0d", c), 64'(bus.mul_result), 64'(held));
      check($sformatf("bp_ready_c%0d", c),  64'(bus.in_ready),   64'd0);
    end
    // New request and out_ready together in DONE: not accepted.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    #1;
    check("bp_no_back_to_back", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("bp_release_in_ready",  64'(bus.in_ready),  64'd1);
    check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);

    // ---- Flush on the 10th BUSY edge ---------------------------------------
    accept_req(MUL_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_busy_in_ready",  64'(bus.in_ready),  64'd1);
    check("flush_busy_out_valid", 64'(bus.out_valid), 64'd0);
    seen = 0;
    for (int c = 0; c < ITER + 4; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("flush_busy_no_valid", 64'(seen), 64'd0);
    run_op(MUL_MULHU, 32'h0001_0000, 32'h0001_0000, res, lat);
    check("after_flush_result",  64'(res), 64'h1);
    check("after_flush_latency", 64'(lat), 64'(ITER));
    release_result();

    // ---- Flush in IDLE blocks a concurrent request --------------------------
    bus.flush    = 1'b1;
    bus.mul_op   = MUL_MUL;
    bus.src_a    = 32'h0000_0005;
    bus.src_b    = 32'h0000_0005;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_idle_in_ready", 64'(bus.in_ready), 64'd1);
    seen = 0;
    for (int c = 0; c < ITER + 4; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("flush_idle_no_valid", 64'(seen), 64'd0);

    // ---- Flush in DONE discards the result ---------------------------------
    run_op(MUL_MUL, 32'h0000_0003, 32'h0000_0004, res, lat);
    check("flush_done_result", 64'(res), 64'hC);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_done_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_done_in_ready",  64'(bus.in_ready),  64'd1);

    // ---- Reset mid-BUSY overrides flush and in_valid ---------------------------
    accept_req(MUL_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) @(posedge clk);
    #1;
    rst_n        = 1'b0;
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_busy_in_ready",   64'(bus.in_ready),   64'd1);
    check("rst_busy_out_valid",  64'(bus.out_valid),  64'd0);
    check("rst_busy_mul_result", 64'(bus.mul_result), 64'h0);

    // ---- Sanity op after mid-operation reset ----------------------------------
    run_op(MUL_MULH, 32'h0000_0002, 32'hFFFF_FFFE, res, lat);
    check("after_rst_result",  64'(res), 64'hFFFF_FFFF);
    check("after_rst_latency", 64'(lat), 64'(ITER));
    release_result();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_core_mul_seq
